// File: rtl/nav_pkg.sv
// Shared types and helpers for the timed wall-follower navigation FSM.
// Holds the state encoding, default RPM constants and heading priority.
package nav_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_FORWARD     = 3'd1,
        ST_TURN_LEFT   = 3'd2,
        ST_TURN_RIGHT  = 3'd3,
        ST_TURN_AROUND = 3'd4
    } nav_state_t;

    localparam int DEF_CRUISE_RPM = 100;
    localparam int DEF_INNER_RPM  = 50;

    // Right-hand rule: right, then forward, then left, else turn around.
    function automatic nav_state_t pick_candidate(
        input logic open_r,
        input logic open_f,
        input logic open_l
    );
        if (open_r)
            return ST_TURN_RIGHT;
        else if (open_f)
            return ST_FORWARD;
        else if (open_l)
            return ST_TURN_LEFT;
        else
            return ST_TURN_AROUND;
    endfunction

endpackage

// File: rtl/ir_hyst_comparator.sv
// Registered "path open" flag for one IR sensor with a hysteresis band.
// Ports: clk_in, reset_n_in, ir_in, threshold_in, hyst_in -> open_flag.
module ir_hyst_comparator #(
    parameter int IR_WIDTH = 16
) (
    input  logic                clk_in,
    input  logic                reset_n_in,
    input  logic [IR_WIDTH-1:0] ir_in,
    input  logic [IR_WIDTH-1:0] threshold_in,
    input  logic [IR_WIDTH-1:0] hyst_in,
    output logic                open_flag
);

    // One extra bit so a large threshold plus band never wraps low.
    logic [IR_WIDTH:0] set_level;

    assign set_level = {1'b0, threshold_in} + {1'b0, hyst_in};

    always_ff @(posedge clk_in) begin
        if (!reset_n_in)
            open_flag <= 1'b0;
        else if ({1'b0, ir_in} >= set_level)
            open_flag <= 1'b1;
        else if (ir_in < threshold_in)
            open_flag <= 1'b0;
    end

endmodule

// File: rtl/nav_fsm_timed.sv
// Wall-follower navigation FSM with filtered sensors and timed turns.
// Inputs: clk_in, reset_n_in (sync, active low), enable_in, right/left/
// forward_ir_in, threshold_in, hyst_in. Outputs: per-motor RPM setpoints,
// enables, directions, state_out (debug) and a turn_done pulse.
// Optional NAV_SETPOINT_RAMP_EN: setpoints slew by RAMP_STEP per cycle.
module nav_fsm_timed
    import nav_pkg::*;
#(
    parameter int IR_WIDTH       = 16,
    parameter int RPM_WIDTH      = 26,
    parameter int CRUISE_RPM     = DEF_CRUISE_RPM,
    parameter int INNER_RPM      = DEF_INNER_RPM,
    parameter int TURN_CYCLES    = 50_000_000,
    parameter int UTURN_CYCLES   = 100_000_000,
    parameter int MIN_FWD_CYCLES = 10_000_000,
    parameter int CONFIRM_CYCLES = 1000,
    parameter int RAMP_STEP      = 1
) (
    input  logic                 clk_in,
    input  logic                 reset_n_in,
    input  logic                 enable_in,
    input  logic [IR_WIDTH-1:0]  right_ir_in,
    input  logic [IR_WIDTH-1:0]  left_ir_in,
    input  logic [IR_WIDTH-1:0]  forward_ir_in,
    input  logic [IR_WIDTH-1:0]  threshold_in,
    input  logic [IR_WIDTH-1:0]  hyst_in,
    output logic [RPM_WIDTH-1:0] rpm_left_setpoint,
    output logic [RPM_WIDTH-1:0] rpm_right_setpoint,
    output logic                 left_motor_en,
    output logic                 right_motor_en,
    output logic                 left_motor_direction,
    output logic                 right_motor_direction,
    output logic [2:0]           state_out,
    output logic                 turn_done
);

    localparam int DW   = $clog2(MIN_FWD_CYCLES + 1);
    localparam int CW   = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
    localparam int TMAX = (UTURN_CYCLES > TURN_CYCLES) ? UTURN_CYCLES
                                                       : TURN_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [DW-1:0] DWELL_MAX  = DW'(MIN_FWD_CYCLES);
    localparam logic [CW-1:0] CONF_MAX   = CW'(CONFIRM_CYCLES - 1);
    localparam logic [TW-1:0] TURN_LOAD  = TW'(TURN_CYCLES - 1);
    localparam logic [TW-1:0] UTURN_LOAD = TW'(UTURN_CYCLES - 1);

    localparam logic [RPM_WIDTH-1:0] RPM_CRUISE = RPM_WIDTH'(CRUISE_RPM);
    localparam logic [RPM_WIDTH-1:0] RPM_INNER  = RPM_WIDTH'(INNER_RPM);

    nav_state_t          state;
    nav_state_t          state_nxt;
    nav_state_t          cand;
    nav_state_t          prev_cand;
    logic [DW-1:0]       dwell_cnt;
    logic [CW-1:0]       confirm_cnt;
    logic [TW-1:0]       turn_timer;
    logic [TW-1:0]       timer_nxt;
    logic                done_nxt;
    logic                open_r;
    logic                open_f;
    logic                open_l;
    logic [RPM_WIDTH-1:0] tgt_left;
    logic [RPM_WIDTH-1:0] tgt_right;

    ir_hyst_comparator #(.IR_WIDTH(IR_WIDTH)) u_cmp_right (
        .clk_in       (clk_in),
        .reset_n_in   (reset_n_in),
        .ir_in        (right_ir_in),
        .threshold_in (threshold_in),
        .hyst_in      (hyst_in),
        .open_flag    (open_r)
    );

    ir_hyst_comparator #(.IR_WIDTH(IR_WIDTH)) u_cmp_forward (
        .clk_in       (clk_in),
        .reset_n_in   (reset_n_in),
        .ir_in        (forward_ir_in),
        .threshold_in (threshold_in),
        .hyst_in      (hyst_in),
        .open_flag    (open_f)
    );

    ir_hyst_comparator #(.IR_WIDTH(IR_WIDTH)) u_cmp_left (
        .clk_in       (clk_in),
        .reset_n_in   (reset_n_in),
        .ir_in        (left_ir_in),
        .threshold_in (threshold_in),
        .hyst_in      (hyst_in),
        .open_flag    (open_l)
    );

    assign cand = pick_candidate(open_r, open_f, open_l);

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state       <= ST_IDLE;
            prev_cand   <= ST_IDLE;
            dwell_cnt   <= '0;
            confirm_cnt <= '0;
            turn_timer  <= '0;
            turn_done   <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev_cand  <= cand;
            turn_timer <= timer_nxt;
            turn_done  <= done_nxt;

            // Persistence: only a stable, non-forward heading accumulates.
            if (cand != ST_FORWARD && cand == prev_cand) begin
                if (confirm_cnt != CONF_MAX)
                    confirm_cnt <= confirm_cnt + 1'b1;
            end else begin
                confirm_cnt <= '0;
            end

            if (state_nxt == ST_FORWARD && state != ST_FORWARD)
                dwell_cnt <= '0;
            else if (state == ST_FORWARD && dwell_cnt != DWELL_MAX)
                dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = turn_timer;
        done_nxt  = 1'b0;

        if (state != ST_IDLE && !enable_in) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable_in)
                        state_nxt = ST_FORWARD;
                end
                ST_FORWARD: begin
                    if (dwell_cnt == DWELL_MAX &&
                        confirm_cnt == CONF_MAX &&
                        cand != ST_FORWARD) begin
                        state_nxt = cand;
                        timer_nxt = (cand == ST_TURN_AROUND) ? UTURN_LOAD
                                                             : TURN_LOAD;
                    end
                end
                ST_TURN_LEFT, ST_TURN_RIGHT, ST_TURN_AROUND: begin
                    if (turn_timer == '0) begin
                        state_nxt = ST_FORWARD;
                        done_nxt  = 1'b1;
                    end else begin
                        timer_nxt = turn_timer - 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tgt_left              = '0;
        tgt_right             = '0;
        left_motor_en         = 1'b0;
        right_motor_en        = 1'b0;
        left_motor_direction  = 1'b1;
        right_motor_direction = 1'b1;

        case (state)
            ST_FORWARD: begin
                left_motor_en  = 1'b1;
                right_motor_en = 1'b1;
                tgt_left       = RPM_CRUISE;
                tgt_right      = RPM_CRUISE;
            end
            ST_TURN_LEFT: begin
                left_motor_en  = 1'b1;
                right_motor_en = 1'b1;
                tgt_left       = RPM_INNER;
                tgt_right      = RPM_CRUISE;
            end
            ST_TURN_RIGHT: begin
                left_motor_en  = 1'b1;
                right_motor_en = 1'b1;
                tgt_left       = RPM_CRUISE;
                tgt_right      = RPM_INNER;
            end
            ST_TURN_AROUND: begin
                left_motor_en         = 1'b1;
                right_motor_en        = 1'b1;
                tgt_left              = RPM_CRUISE;
                tgt_right             = RPM_CRUISE;
                right_motor_direction = 1'b0;
            end
            default: ;
        endcase
    end

    assign state_out = state;

`ifdef NAV_SETPOINT_RAMP_EN
    localparam int RW1 = RPM_WIDTH + 1;
    localparam logic [RPM_WIDTH:0] STEP = RW1'(RAMP_STEP);

    // Move one step toward the target, landing exactly on it.
    function automatic logic [RPM_WIDTH-1:0] ramp(
        input logic [RPM_WIDTH-1:0] cur,
        input logic [RPM_WIDTH-1:0] tgt
    );
        logic [RPM_WIDTH:0] up;
        logic [RPM_WIDTH:0] gap;
        up  = {1'b0, cur} + STEP;
        gap = {1'b0, cur - tgt};
        if (cur < tgt)
            ramp = (up >= {1'b0, tgt}) ? tgt : up[RPM_WIDTH-1:0];
        else
            ramp = (gap <= STEP) ? tgt : cur - STEP[RPM_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            rpm_left_setpoint  <= '0;
            rpm_right_setpoint <= '0;
        end else begin
            rpm_left_setpoint  <= ramp(rpm_left_setpoint, tgt_left);
            rpm_right_setpoint <= ramp(rpm_right_setpoint, tgt_right);
        end
    end
`else
    logic unused_ramp;

    assign unused_ramp        = ^RAMP_STEP;
    assign rpm_left_setpoint  = tgt_left;
    assign rpm_right_setpoint = tgt_right;
`endif

endmodule

// File: tb/tb_nav_fsm_timed.sv
// Scoreboard bench for nav_fsm_timed against a behavioural model.
// Directed scenarios followed by randomized sensor/enable/reset traffic.
module tb_nav_fsm_timed;

    localparam int MINF = 4;
    localparam int CONF = 3;
    localparam int TC   = 8;
    localparam int UT   = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] r_ir;
    logic [15:0] l_ir;
    logic [15:0] f_ir;
    logic [15:0] thr;
    logic [15:0] hyst;

    logic [25:0] sp_l;
    logic [25:0] sp_r;
    logic        en_l;
    logic        en_r;
    logic        dir_l;
    logic        dir_r;
    logic [2:0]  st;
    logic        done;

    always #5 clk = ~clk;

    nav_fsm_timed #(
        .TURN_CYCLES    (TC),
        .UTURN_CYCLES   (UT),
        .MIN_FWD_CYCLES (MINF),
        .CONFIRM_CYCLES (CONF)
    ) dut (
        .clk_in                (clk),
        .reset_n_in            (rst_n),
        .enable_in             (en),
        .right_ir_in           (r_ir),
        .left_ir_in            (l_ir),
        .forward_ir_in         (f_ir),
        .threshold_in          (thr),
        .hyst_in               (hyst),
        .rpm_left_setpoint     (sp_l),
        .rpm_right_setpoint    (sp_r),
        .left_motor_en         (en_l),
        .right_motor_en        (en_r),
        .left_motor_direction  (dir_l),
        .right_motor_direction (dir_r),
        .state_out             (st),
        .turn_done             (done)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic [25:0] spl;
        logic [25:0] spr;
        logic        enl;
        logic        enr;
        logic        dl;
        logic        dr;
        logic        done;
    } obs_t;

    obs_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: 0 idle, 1 forward, 2 left, 3 right, 4 around.
    int ms;
    int prev;
    int run;
    int age;
    int rem;
    bit mdone;
    bit mo_r;
    bit mo_f;
    bit mo_l;

    function automatic int heading(bit r, bit f, bit l);
        if (r) return 3;
        if (f) return 1;
        if (l) return 2;
        return 4;
    endfunction

    function automatic bit flag_next(bit cur, int ir, int t, int h);
        if (ir >= t + h) return 1'b1;
        if (ir < t) return 1'b0;
        return cur;
    endfunction

    function automatic obs_t expect_out();
        obs_t o;
        o.st   = 3'(ms);
        o.done = mdone;
        o.dl   = 1'b1;
        o.dr   = (ms == 4) ? 1'b0 : 1'b1;
        o.enl  = (ms != 0);
        o.enr  = (ms != 0);
        o.spl  = (ms == 0) ? 26'd0 : (ms == 2) ? 26'd50 : 26'd100;
        o.spr  = (ms == 0) ? 26'd0 : (ms == 3) ? 26'd50 : 26'd100;
        return o;
    endfunction

    task automatic model_step();
        int cand;
        int nstate;
        int nage;
        int nrem;
        bit ndone;
        if (!rst_n) begin
            ms = 0; prev = 0; run = 0; age = 0; rem = 0;
            mdone = 0; mo_r = 0; mo_f = 0; mo_l = 0;
        end else begin
            cand   = heading(mo_r, mo_f, mo_l);
            nstate = ms;
            nage   = age;
            nrem   = rem;
            ndone  = 0;
            if (ms != 0 && !en) begin
                nstate = 0;
            end else if (ms == 0) begin
                if (en) begin
                    nstate = 1;
                    nage   = 0;
                end
            end else if (ms == 1) begin
                if (age >= MINF && run >= CONF - 1 && cand != 1) begin
                    nstate = cand;
                    nrem   = ((cand == 4) ? UT : TC) - 1;
                end else begin
                    nage = age + 1;
                end
            end else begin
                if (rem == 0) begin
                    nstate = 1;
                    nage   = 0;
                    ndone  = 1;
                end else begin
                    nrem = rem - 1;
                end
            end
            run   = (cand != 1 && cand == prev) ? run + 1 : 0;
            prev  = cand;
            ms    = nstate;
            age   = nage;
            rem   = nrem;
            mdone = ndone;
            mo_r  = flag_next(mo_r, int'(r_ir), int'(thr), int'(hyst));
            mo_f  = flag_next(mo_f, int'(f_ir), int'(thr), int'(hyst));
            mo_l  = flag_next(mo_l, int'(l_ir), int'(thr), int'(hyst));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        q.push_back(expect_out());
    endtask

    task automatic run_n(int n);
        repeat (n) tick();
    endtask

    task automatic wait_state(int s, int max_cycles);
        int k = 0;
        while (int'(st) != s && k < max_cycles) begin
            tick();
            k++;
        end
        checks++;
        if (int'(st) != s) begin
            errors++;
            $display("FAIL wait_state got %0d need %0d", st, s);
        end
    endtask

    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {st, sp_l, sp_r, en_l, en_r, dir_l, dir_r, done};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t act st=%0d sp=%0d/%0d en=%b%b dir=%b%b done=%b exp st=%0d sp=%0d/%0d en=%b%b dir=%b%b done=%b",
                             $time, a.st, a.spl, a.spr, a.enl, a.enr,
                             a.dl, a.dr, a.done, e.st, e.spl, e.spr,
                             e.enl, e.enr, e.dl, e.dr, e.done);
                end
            end
        end
    end

    int vals[9] = '{0, 500, 999, 1000, 1050, 1099, 1100, 2000, 65535};

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        r_ir  = '0;
        l_ir  = '0;
        f_ir  = '0;
        thr   = 16'd1000;
        hyst  = 16'd100;
        run_n(3);

        rst_n = 1'b1;
        en    = 1'b1;
        f_ir  = 16'd2000;
        run_n(20);

        r_ir = 16'd1200;
        wait_state(3, 40);
        run_n(30);

        r_ir = 16'd500;
        l_ir = 16'd500;
        f_ir = 16'd500;
        wait_state(4, 80);
        run_n(25);

        f_ir = 16'd2000;
        r_ir = 16'd1050;
        run_n(30);
        r_ir = 16'd1100;
        wait_state(3, 40);
        run_n(12);
        r_ir = 16'd999;
        run_n(20);

        for (int i = 0; i < 40; i++) begin
            r_ir = ((i / 2) % 2 == 1) ? 16'd1200 : 16'd0;
            tick();
        end

        r_ir = 16'd0;
        f_ir = 16'd0;
        l_ir = 16'd2000;
        wait_state(2, 60);
        run_n(3);
        en = 1'b0;
        run_n(3);
        en = 1'b1;
        wait_state(2, 60);
        run_n(2);
        rst_n = 1'b0;
        run_n(2);
        rst_n = 1'b1;
        run_n(5);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)
                r_ir = 16'(vals[$urandom_range(0, 8)]);
            if ($urandom_range(0, 7) == 0)
                f_ir = 16'(vals[$urandom_range(0, 8)]);
            if ($urandom_range(0, 7) == 0)
                l_ir = 16'(vals[$urandom_range(0, 8)]);
            if ($urandom_range(0, 99) == 0)
                en = ~en;
            else if (!en && $urandom_range(0, 9) == 0)
                en = 1'b1;
            if ($urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 2))
                    0: begin thr = 16'd1000; hyst = 16'd100; end
                    1: begin thr = 16'd65000; hyst = 16'd1000; end
                    default: begin
                        thr  = 16'($urandom_range(0, 3000));
                        hyst = 16'($urandom_range(0, 300));
                    end
                endcase
            end
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n = 1'b1;
        run_n(2);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
